seq_scan_ctrl: RTL and testbench

Word-fed serial pattern scanner and controller. Accepts parallel data words over a valid/ready handshake, serializes them MSB-first into a continuous bit stream, and runs a programmable 1–4-bit pattern match (overlapping or non-overlapping) on that stream. Match results are reported as pulses and as a saturating count. The block sequences the lab's serial sequence-detection datapath from a word-oriented source, and is configured by a host between words.

---
 rtl/seq_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: word-fed serial pattern scanner.
// Accepts DW-bit words on a valid/ready handshake and shifts them out MSB-first
// as a bit stream. It matches a programmable 1..4-bit pattern (overlapping or
// non-overlapping) against that stream and reports each hit as a pulse and in a
// saturating counter.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cfg_we/cfg_pattern/cfg_len/cfg_overlap  config write (IDLE only)
//   clr_cnt                           sync clear of match_cnt (wins over increment)
//   in_valid/in_data/in_ready         word input handshake
//   bit_valid/bit_out                 serialized stream (combinational)
//   match/match_cnt                   registered hit pulse and saturating count
//   word_done/busy                    DONE-state pulse, state != IDLE
module seq_scan_ctrl #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_pattern,
    input  logic [2:0]    cfg_len,
    input  logic          cfg_overlap,
    input  logic          clr_cnt,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          bit_valid,
    output logic          bit_out,
    output logic          match,
    output logic [CW-1:0] match_cnt,
    output logic          word_done,
    output logic          busy
);

    localparam int unsigned BCW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   sreg_q, sreg_d;
    logic [BCW-1:0]  bcnt_q, bcnt_d;
    logic [3:0]      hist_q, hist_d;
    logic [2:0]      hcnt_q, hcnt_d;
    logic [3:0]      pat_q, pat_d;
    logic [2:0]      len_q, len_d;
    logic            ovl_q, ovl_d;
    logic            match_q, match_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            bit_c;
    logic [3:0]      hist_upd_c;
    logic [2:0]      hcnt_upd_c;
    logic [3:0]      len_mask_c;
    logic            hit_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            hist_q  <= '0;
            hcnt_q  <= '0;
            pat_q   <= '0;
            len_q   <= 3'd4;
            ovl_q   <= 1'b1;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            hist_q  <= hist_d;
            hcnt_q  <= hcnt_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, scan and counter logic
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        hist_d  = hist_q;
        hcnt_d  = hcnt_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;

        bit_c      = (state_q == ST_SHIFT) & sreg_q[DW-1];
        hist_upd_c = {hist_q[2:0], bit_c};
        hcnt_upd_c = (hcnt_q >= 3'd4) ? 3'd4 : hcnt_q + 3'd1;
        case (len_q)
            3'd1:    len_mask_c = 4'b0001;
            3'd2:    len_mask_c = 4'b0011;
            3'd3:    len_mask_c = 4'b0111;
            default: len_mask_c = 4'b1111;
        endcase
        hit_c = (hcnt_upd_c >= len_q) && (((hist_upd_c ^ pat_q) & len_mask_c) == 4'b0000);

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    pat_d  = cfg_pattern;
                    len_d  = ((cfg_len == 3'd0) || (cfg_len > 3'd4)) ? 3'd4 : cfg_len;
                    ovl_d  = cfg_overlap;
                    hist_d = '0;
                    hcnt_d = '0;
                end
                if (in_valid) begin
                    sreg_d  = in_data;
                    bcnt_d  = BCW'(DW - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d  = sreg_q << 1;
                hist_d  = hist_upd_c;
                // Non-overlapping mode restarts the fill count after a hit
                hcnt_d  = (hit_c && !ovl_q) ? 3'd0 : hcnt_upd_c;
                match_d = hit_c;
                if (bcnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    bcnt_d = bcnt_q - BCW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear takes priority over a same-cycle increment
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign bit_valid = (state_q == ST_SHIFT);
    assign bit_out   = bit_c;
    assign word_done = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl (DW = 8, CW = 4): per-word cycle masks
// indexed by cycles after the accepting edge (index j = cycle T0+j).
module tb_seq_scan_ctrl;

    logic       clk;
    logic       reset_n;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       clr_cnt;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       bit_valid;
    logic       bit_out;
    logic       match;
    logic [3:0] match_cnt;
    logic       word_done;
    logic       busy;

    int checks;
    int errors;

    logic [15:0] m_mask, wd_mask, bv_mask, rdy_mask, busy_mask;
    logic [7:0]  bits;
    logic [3:0]  cnt_s [0:15];
    logic        wd_seen;

    seq_scan_ctrl #(.DW(8), .CW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .clr_cnt    (clr_cnt),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .match      (match),
        .match_cnt  (match_cnt),
        .word_done  (word_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    // Send one word; optional config with the word (do_cfg), clr_cnt during
    // cycle clr_j, or config write during cycle cfg_j (0 = none).
    task automatic run_word(input logic [7:0] d, input logic do_cfg,
                            input logic [3:0] pat, input logic [2:0] len, input logic ov,
                            input int clr_j, input int cfg_j);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) check("rdy_timeout", 32'(in_ready), 32'd1);
        m_mask = '0; wd_mask = '0; bv_mask = '0; rdy_mask = '0; busy_mask = '0; bits = '0;
        in_data     = d;
        in_valid    = 1'b1;
        cfg_we      = do_cfg;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        for (int j = 1; j <= 10; j++) begin
            tick();
            in_valid     = 1'b0;
            m_mask[j]    = match;
            wd_mask[j]   = word_done;
            bv_mask[j]   = bit_valid;
            rdy_mask[j]  = in_ready;
            busy_mask[j] = busy;
            cnt_s[j]     = match_cnt;
            if (j <= 8) bits[8-j] = bit_out;
            clr_cnt = (j == clr_j);
            cfg_we  = (j == cfg_j);
        end
        clr_cnt = 1'b0;
        cfg_we  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        clr_cnt = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_bv",    32'(bit_valid), 32'd0);
        check("rst_bit",   32'(bit_out), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_cnt",   32'(match_cnt), 32'd0);
        check("rst_wd",    32'(word_done), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // 0xAA, pattern 1010, overlapping
        run_word(8'hAA, 1'b1, 4'b1010, 3'd4, 1'b1, 0, 0);
        check("aa_ov_match", 32'(m_mask), 32'h02A0);
        check("aa_ov_wd",    32'(wd_mask), 32'h0200);
        check("aa_ov_bv",    32'(bv_mask), 32'h01FE);
        check("aa_ov_rdy",   32'(rdy_mask), 32'h0400);
        check("aa_ov_busy",  32'(busy_mask), 32'h03FE);
        check("aa_ov_bits",  32'(bits), 32'hAA);
        check("aa_ov_cnt",   32'(match_cnt), 32'd3);

        // Non-overlapping
        clear_cnt();
        run_word(8'hAA, 1'b1, 4'b1010, 3'd4, 1'b0, 0, 0);
        check("aa_nov_match", 32'(m_mask), 32'h0220);
        check("aa_nov_cnt",   32'(match_cnt), 32'd2);

        // Boundary-spanning match: 0x01 then 0x40
        clear_cnt();
        run_word(8'h01, 1'b1, 4'b1010, 3'd4, 1'b1, 0, 0);
        check("b1_match", 32'(m_mask), 32'h0000);
        run_word(8'h40, 1'b0, 4'b0000, 3'd0, 1'b0, 0, 0);
        check("b2_match", 32'(m_mask), 32'h0010);
        check("b2_cnt",   32'(match_cnt), 32'd1);

        // Config write during SHIFT is ignored
        clear_cnt();
        run_word(8'hAA, 1'b0, 4'b0001, 3'd1, 1'b1, 0, 2);
        check("midcfg_match", 32'(m_mask), 32'h02A0);
        check("midcfg_cnt",   32'(match_cnt), 32'd3);

        // Same config in IDLE: every bit of 0xFF matches
        clear_cnt();
        run_word(8'hFF, 1'b1, 4'b0001, 3'd1, 1'b1, 0, 0);
        check("ff1_match", 32'(m_mask), 32'h03FC);
        check("ff1_cnt",   32'(match_cnt), 32'd8);

        // Saturation at 15
        run_word(8'hFF, 1'b0, 4'b0000, 3'd0, 1'b0, 0, 0);
        check("sat_cnt7",  32'(cnt_s[7]), 32'd14);
        check("sat_cnt8",  32'(cnt_s[8]), 32'd15);
        check("sat_match", 32'(m_mask), 32'h03FC);
        check("sat_final", 32'(match_cnt), 32'd15);

        // Clear coincident with a match wins
        run_word(8'hFF, 1'b0, 4'b0000, 3'd0, 1'b0, 4, 0);
        check("clr_pre",   32'(cnt_s[4]), 32'd15);
        check("clr_at",    32'(cnt_s[5]), 32'd0);
        check("clr_match", 32'(m_mask), 32'h03FC);
        check("clr_final", 32'(match_cnt), 32'd4);

        // Async reset during bit 3 of 0xAA
        in_data  = 8'hAA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("mid_bv", 32'(bit_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_bv",    32'(bit_valid), 32'd0);
        check("arst_bit",   32'(bit_out), 32'd0);
        check("arst_match", 32'(match), 32'd0);
        check("arst_cnt",   32'(match_cnt), 32'd0);
        check("arst_wd",    32'(word_done), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        wd_seen = 1'b0;
        repeat (2) begin
            tick();
            wd_seen |= word_done;
        end
        reset_n = 1'b1;
        repeat (10) begin
            tick();
            wd_seen |= word_done;
        end
        check("arst_no_wd", 32'(wd_seen), 32'd0);

        // Reset config is pattern 0000, len 4, overlap 1 with empty history
        run_word(8'h0A, 1'b0, 4'b0000, 3'd0, 1'b0, 0, 0);
        check("post_rst_match", 32'(m_mask), 32'h0020);
        check("post_rst_cnt",   32'(match_cnt), 32'd1);

        run_word(8'h0A, 1'b1, 4'b1010, 3'd4, 1'b1, 0, 0);
        check("post_0a_match", 32'(m_mask), 32'h0200);
        check("post_0a_cnt",   32'(match_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
